// File: rtl/ultrasonic_pkg.sv
// Shared types and constants for the multi-channel ultrasonic ranging scheduler.
// Holds the slot FSM encoding, distance codes and a width helper.
package ultrasonic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_RISE,
      MEASURE,
      HOLDOFF
   } state_t;

   localparam int          US_PER_CM    = 58;
   localparam logic [15:0] DIST_TIMEOUT = 16'hFFFF;
   localparam logic [15:0] DIST_MAX     = 16'hFFFE;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/echo_sync_edge.sv
// Two-flop synchronizer for one raw echo pin with rise/fall pulses on the synced level.
// Edge pulses appear 2 clocks after the pin changes; no backpressure.
module echo_sync_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic echo_i,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= echo_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rise_o = sync_q & ~prev_q;
   assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/ultrasonic_scan_scheduler.sv
// Round-robin scheduler sharing one trigger/echo/cm engine across NUM_CH sensors.
// One tagged result per slot, 3 clocks after the echo pin falls; no backpressure on results.
module ultrasonic_scan_scheduler #(
   parameter int NUM_CH     = 4,
   parameter int CYC_PER_US = 100,
   parameter int TRIG_US    = 10,
   parameter int SLOT_US    = 60000,
   parameter int RISE_TO_US = 5000,
   parameter int ECHO_TO_US = 30000,
   parameter int US_PER_CM  = ultrasonic_pkg::US_PER_CM,
   localparam int CH_W      = ultrasonic_pkg::clog2(NUM_CH)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   input  logic [NUM_CH-1:0] ch_mask_i,
   input  logic [NUM_CH-1:0] echo_i,
   output logic [NUM_CH-1:0] trig_o,
   output logic              busy_o,
   output logic [CH_W-1:0]   cur_ch_o,
   output logic              dist_valid_o,
   output logic [CH_W-1:0]   dist_ch_o,
   output logic [15:0]       dist_cm_o,
   output logic              dist_to_o
);

   import ultrasonic_pkg::*;

   localparam int TRIG_CLK = TRIG_US * CYC_PER_US;
   localparam int SLOT_CLK = SLOT_US * CYC_PER_US;
   localparam int RISE_CLK = RISE_TO_US * CYC_PER_US;
   localparam int ECHO_CLK = ECHO_TO_US * CYC_PER_US;
   localparam int TMR_MAX0 = (TRIG_CLK > RISE_CLK) ? TRIG_CLK : RISE_CLK;
   localparam int TMR_MAX  = (TMR_MAX0 > ECHO_CLK + 1) ? TMR_MAX0 : ECHO_CLK + 1;
   localparam int TMR_W    = clog2(TMR_MAX + 1);
   localparam int SLOT_W   = clog2(SLOT_CLK + 1);
   localparam int PRE_W    = clog2(CYC_PER_US + 1);
   localparam int USC_W    = clog2(US_PER_CM + 1);

   logic [NUM_CH-1:0] rise_vec;
   logic [NUM_CH-1:0] fall_vec;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
      echo_sync_edge u_sync (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .echo_i (echo_i[g]),
         .rise_o (rise_vec[g]),
         .fall_o (fall_vec[g])
      );
   end

   state_t            state_q, state_d;
   logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
   logic              first_q, first_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [PRE_W-1:0]  pre_q, pre_d;
   logic [USC_W-1:0]  usc_q, usc_d, usc_b;
   logic [15:0]       cm_q, cm_d, cm_b;
   logic              dist_valid_q;
   logic [CH_W-1:0]   dist_ch_q;
   logic [15:0]       dist_cm_q;
   logic              dist_to_q;

   logic              us_tick;
   logic              sel_ok;
   logic              rise_sel;
   logic              fall_sel;
   logic              launch;
   logic              meas_start;
   logic              emit;
   logic              emit_to;
   logic [CH_W-1:0]   pick;
   logic [CH_W-1:0]   idx_c;
   int                start;

   assign us_tick  = (pre_q == PRE_W'(CYC_PER_US - 1));
   assign pre_d    = us_tick ? '0 : pre_q + 1'b1;
   assign sel_ok   = enable_i && (ch_mask_i != '0);
   assign rise_sel = rise_vec[cur_ch_q];
   assign fall_sel = fall_vec[cur_ch_q];

   // Search starts strictly after cur_ch, except the first pick after reset which includes ch 0.
   always_comb begin
      pick  = cur_ch_q;
      idx_c = '0;
      start = first_q ? int'(cur_ch_q) : int'(cur_ch_q) + 1;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         idx_c = CH_W'((start + i) % NUM_CH);
         if (ch_mask_i[idx_c]) pick = idx_c;
      end
   end

   always_comb begin
      state_d    = state_q;
      cur_ch_d   = cur_ch_q;
      first_d    = first_q;
      tmr_d      = '0;
      slot_d     = (state_q == IDLE) ? '0 : slot_q + 1'b1;
      launch     = 1'b0;
      meas_start = 1'b0;
      emit       = 1'b0;
      emit_to    = 1'b0;
      unique case (state_q)
         IDLE: launch = sel_ok;
         TRIG: begin
            if (tmr_q == TMR_W'(TRIG_CLK - 1)) state_d = WAIT_RISE;
            else tmr_d = tmr_q + 1'b1;
         end
         WAIT_RISE: begin
            // The rise cycle itself is the first counted cycle of the echo width.
            if (rise_sel) begin
               state_d    = MEASURE;
               tmr_d      = TMR_W'(1);
               meas_start = 1'b1;
            end else if (tmr_q == TMR_W'(RISE_CLK - 1)) begin
               emit    = 1'b1;
               emit_to = 1'b1;
               state_d = HOLDOFF;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         MEASURE: begin
            if (fall_sel) begin
               emit    = 1'b1;
               state_d = HOLDOFF;
            end else if (tmr_q == TMR_W'(ECHO_CLK)) begin
               emit    = 1'b1;
               emit_to = 1'b1;
               state_d = HOLDOFF;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         HOLDOFF: begin
            if (slot_q >= SLOT_W'(SLOT_CLK - 1)) begin
               if (sel_ok) launch = 1'b1;
               else state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (launch) begin
         state_d  = TRIG;
         cur_ch_d = pick;
         first_d  = 1'b0;
         slot_d   = '0;
         tmr_d    = '0;
      end
   end

   always_comb begin
      usc_d = usc_q;
      cm_d  = cm_q;
      usc_b = meas_start ? '0 : usc_q;
      cm_b  = meas_start ? '0 : cm_q;
      if (meas_start || (state_q == MEASURE && !fall_sel)) begin
         usc_d = usc_b;
         cm_d  = cm_b;
         if (us_tick) begin
            if (usc_b == USC_W'(US_PER_CM - 1)) begin
               usc_d = '0;
               if (cm_b != DIST_MAX) cm_d = cm_b + 1'b1;
            end else begin
               usc_d = usc_b + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q      <= IDLE;
         cur_ch_q     <= '0;
         first_q      <= 1'b1;
         tmr_q        <= '0;
         slot_q       <= '0;
         pre_q        <= '0;
         usc_q        <= '0;
         cm_q         <= '0;
         dist_valid_q <= 1'b0;
         dist_ch_q    <= '0;
         dist_cm_q    <= '0;
         dist_to_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_ch_q     <= cur_ch_d;
         first_q      <= first_d;
         tmr_q        <= tmr_d;
         slot_q       <= slot_d;
         pre_q        <= pre_d;
         usc_q        <= usc_d;
         cm_q         <= cm_d;
         dist_valid_q <= emit;
         if (emit) begin
            dist_ch_q <= cur_ch_q;
            dist_cm_q <= emit_to ? DIST_TIMEOUT : cm_q;
            dist_to_q <= emit_to;
         end
      end
   end

   always_comb begin
      trig_o = '0;
      if (state_q == TRIG) trig_o[cur_ch_q] = 1'b1;
   end

   assign busy_o       = (state_q != IDLE);
   assign cur_ch_o     = cur_ch_q;
   assign dist_valid_o = dist_valid_q;
   assign dist_ch_o    = dist_ch_q;
   assign dist_cm_o    = dist_cm_q;
   assign dist_to_o    = dist_to_q;

endmodule
